multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ALU_CTRL_W, default 3, giving the width of ALUControl.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port op, input, 7 bits: instr[6:0], taken from the instruction register.
REQ-005 The block SHALL have port funct3, input, 3 bits: instr[14:12].
REQ-006 The block SHALL have port funct7b5, input, 1 bit: instr[30].
REQ-007 The block SHALL have port zero, input, 1 bit: the ALU zero flag.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-009 The block SHALL have ports PCWrite, IRWrite, MemWrite, RegWrite and AdrSrc, each output, 1 bit: datapath enables and the address-mux select.
REQ-010 The block SHALL have ports ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, each output, 2 bits: mux selects; ImmSrc drives the immediate extender.
REQ-011 The block SHALL have port ALUControl, output, ALU_CTRL_W bits: the ALU operation.
REQ-012 The block SHALL have port illegal, output, 1 bit: unsupported opcode detected.
REQ-013 The block SHALL have port retired, output, 32 bits: count of completed instructions.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB and BEQ.
REQ-015 Transitions SHALL be as follows:
- FETCH->DECODE when mem_ready=1, else remain in FETCH.
- DECODE->MEMADR for op 0000011 or 0100011.
- DECODE->EXECR for op 0110011.
- DECODE->EXECI for op 0010011.
- DECODE->BEQ for op 1100011.
- DECODE->FETCH for any other op.
- MEMADR->MEMREAD for a load, ->MEMWRITE for a store.
- MEMREAD->MEMWB when mem_ready=1, else remain in MEMREAD.
- MEMWRITE->FETCH when mem_ready=1, else remain in MEMWRITE.
- MEMWB->FETCH.
- EXECR and EXECI->ALUWB.
- ALUWB->FETCH.
- BEQ->FETCH.
REQ-016 Outputs SHALL be Moore-decoded from state, gated only by mem_ready and zero as listed; any output not listed for a state SHALL be 0:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALU op add; IRWrite=PCWrite=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALU op add.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU op add.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU op decoded.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU op decoded.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, ALU op sub; PCWrite=zero.
REQ-017 ImmSrc SHALL be combinational from op in every state: 0100011->01, 1100011->10, all other ops->00.
REQ-018 ALUControl SHALL be 000 for add and 001 for sub.
REQ-019 In decoded mode, ALUControl SHALL follow funct3:
- 000: 001 if funct7b5=1 and op[5]=1, else 000.
- 010: 101.
- 110: 011.
- 111: 010.
- any other funct3: 000.
REQ-020 illegal SHALL pulse high for exactly the one DECODE cycle in which op is unsupported; that instruction SHALL produce no RegWrite, MemWrite or PCWrite beyond its FETCH.
REQ-021 retired SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
REQ-022 retired SHALL NOT increment for an illegal-opcode return to FETCH.
REQ-023 Latency SHALL be, counting 1 cycle per memory access when mem_ready is continuously 1:
- lw: 5 cycles.
- sw: 4 cycles.
- R-type and I-type ALU: 4 cycles.
- beq: 3 cycles.
Each cycle mem_ready is low while a state waits on it adds exactly 1 cycle.

Reset
REQ-024 While rst_n=0, state SHALL be FETCH, retired SHALL be 0, and PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be forced to 0 regardless of mem_ready.
REQ-025 Assertion of rst_n=0 mid-instruction, including in a wait state, SHALL abort the instruction immediately and asynchronously.
REQ-026 The first FETCH SHALL begin on the first rising edge after rst_n deasserts.

Verification
REQ-027 Hold mem_ready=1 and issue lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, ResultSrc=01; retired goes 0->1.
REQ-028 Issue sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite never 1.
REQ-029 Issue R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; issue addi with funct7b5=1 -> ALUControl=000 in EXECI.
REQ-030 Issue beq with zero=1, then with zero=0 -> PCWrite=1 in BEQ only for the zero=1 case; ImmSrc=10 throughout both.
REQ-031 Issue op 1111111 -> illegal=1 for one cycle in DECODE, return to FETCH, retired unchanged.
REQ-032 Preload retired to 0xFFFFFFFF, then retire one instruction -> retired=0. Separately, assert rst_n=0 in MEMREAD -> state=FETCH and all write enables 0 within the same cycle, without a clock edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl
// Multicycle RISC-V style main controller: Moore FSM, ALU decode, retire count.
// Rev    : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  illegal,
    output logic [31:0]           retired
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_pcwrite;
    logic        w_irwrite;
    logic        w_memwrite;
    logic        w_regwrite;
    logic        w_illegal;
    logic        w_retire;
    logic [2:0]  w_alu;
    logic [2:0]  w_alu_dec;
    logic [31:0] r_retired;

    // funct7b5 only selects sub for register-register ops (op[5]=1), never for addi
    always_comb begin
        case (funct3)
            3'b000:  w_alu_dec = (funct7b5 && op[5]) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_dec = 3'b101;
            3'b110:  w_alu_dec = 3'b011;
            3'b111:  w_alu_dec = 3'b010;
            default: w_alu_dec = c_ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            c_OP_STORE:  ImmSrc = 2'b01;
            c_OP_BRANCH: ImmSrc = 2'b10;
            default:     ImmSrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        w_retire   = 1'b0;
        w_alu      = c_ALU_ADD;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_RTYPE:            w_next = S_EXECR;
                    c_OP_ITYPE:            w_next = S_EXECI;
                    c_OP_BRANCH:           w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                w_alu   = w_alu_dec;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_alu   = w_alu_dec;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                w_alu     = c_ALU_SUB;
                w_pcwrite = zero;
                w_next    = S_FETCH;
                w_retire  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Enables are masked by rst_n directly so FETCH cannot assert them while reset is held
    assign PCWrite    = w_pcwrite  & rst_n;
    assign IRWrite    = w_irwrite  & rst_n;
    assign MemWrite   = w_memwrite & rst_n;
    assign RegWrite   = w_regwrite & rst_n;
    assign illegal    = w_illegal  & rst_n;
    assign ALUControl = ALU_CTRL_W'(w_alu);
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Testbench for multicycle_ctrl: decode table, hand-written multi-cycle
// sequences and a randomized run against a per-instruction phase-list model.
module tb_multicycle_ctrl;

    localparam int ALU_CTRL_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [6:0]            op = 7'b0;
    logic [2:0]            funct3 = 3'b0;
    logic                  funct7b5 = 1'b0;
    logic                  zero = 1'b0;
    logic                  mem_ready = 1'b1;
    logic                  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
    logic [1:0]            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic [31:0]           retired;

    multicycle_ctrl #(.ALU_CTRL_W(ALU_CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_LDRD, P_LDWB, P_STWR,
                      P_EXR, P_EXI, P_ALUWB, P_BR} ph_t;

    ph_t         q[$];
    logic [31:0] m_ret;
    bit          m_ill;
    bit          m_done;

    logic [16:0] w_dut_vec;
    assign w_dut_vec = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                        ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    function automatic logic [2:0] spec_alu(input logic [2:0] f3, input logic f7, input logic op5);
        case (f3)
            3'b000:  return (f7 && op5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    endfunction

    function automatic logic [16:0] model_vec(input ph_t ph, input logic mr);
        logic       pcw = 0, irw = 0, memw = 0, regw = 0, adr = 0, ill = 0;
        logic [1:0] res = 0, sa = 0, sb = 0, imm;
        logic [2:0] alu = 3'b000;
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 : 2'b00;
        case (ph)
            P_FETCH:  begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            P_DECODE: begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
            P_ADDR:   begin sa = 2'b10; sb = 2'b01; end
            P_LDRD:   adr = 1;
            P_LDWB:   begin res = 2'b01; regw = 1; end
            P_STWR:   begin adr = 1; memw = 1; end
            P_EXR:    begin sa = 2'b10; alu = spec_alu(funct3, funct7b5, op[5]); end
            P_EXI:    begin sa = 2'b10; sb = 2'b01; alu = spec_alu(funct3, funct7b5, op[5]); end
            P_ALUWB:  regw = 1;
            P_BR:     begin sa = 2'b10; alu = 3'b001; pcw = zero; end
            default:  ;
        endcase
        return {pcw, irw, memw, regw, adr, res, sa, sb, imm, alu, ill};
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back(P_FETCH);
        q.push_back(P_DECODE);
        m_ret = 32'd0;
        m_ill = 0;
    endtask

    // Each instruction is a list of phases; the recipe tail is chosen from op at decode.
    task automatic model_advance(input logic mr);
        ph_t ph = q[0];
        m_done = 0;
        if (!(ph inside {P_FETCH, P_LDRD, P_STWR}) || mr) begin
            void'(q.pop_front());
            if (ph == P_DECODE) begin
                case (op)
                    7'b0000011: begin q.push_back(P_ADDR); q.push_back(P_LDRD); q.push_back(P_LDWB); end
                    7'b0100011: begin q.push_back(P_ADDR); q.push_back(P_STWR); end
                    7'b0110011: begin q.push_back(P_EXR);  q.push_back(P_ALUWB); end
                    7'b0010011: begin q.push_back(P_EXI);  q.push_back(P_ALUWB); end
                    7'b1100011: q.push_back(P_BR);
                    default:    m_ill = 1;
                endcase
            end
            if (q.size() == 0) begin
                if (!m_ill) m_ret = m_ret + 32'd1;
                m_ill  = 0;
                m_done = 1;
                q.push_back(P_FETCH);
                q.push_back(P_DECODE);
            end
        end
    endtask

    // Runs one instruction from its FETCH; called at posedge+1.
    task automatic run_instr(input logic [6:0] i_op, input logic [2:0] f3, input logic f7,
                             input logic z, input ph_t stall_ph, input int stall_n, input bit rnd,
                             output int cyc, output logic [15:0] rw_m, output logic [15:0] mw_m,
                             output logic [15:0] pw_m, output logic [15:0] il_m,
                             output logic [2:0] alu3, output logic [1:0] imm_first,
                             output bit imm_const);
        int stalls = stall_n;
        ph_t ph;
        op = i_op; funct3 = f3; funct7b5 = f7; zero = z;
        cyc = 0; rw_m = '0; mw_m = '0; pw_m = '0; il_m = '0;
        alu3 = 3'b000; imm_first = 2'b00; imm_const = 1; m_done = 0;
        while (!m_done && cyc < 40) begin
            ph = q[0];
            if (rnd) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                zero      = $urandom_range(0, 1) == 1;
            end else if (ph == stall_ph && stalls > 0) begin
                mem_ready = 1'b0;
                stalls--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            check($sformatf("outputs phase=%0d cyc=%0d op=%b", ph, cyc, op), w_dut_vec, model_vec(ph, mem_ready));
            check($sformatf("retired cyc=%0d", cyc), retired, m_ret);
            if (cyc < 16) begin
                rw_m[cyc] = RegWrite; mw_m[cyc] = MemWrite;
                pw_m[cyc] = PCWrite;  il_m[cyc] = illegal;
            end
            if (cyc == 0) imm_first = ImmSrc;
            else if (ImmSrc !== imm_first) imm_const = 0;
            if (cyc == 2) alu3 = ALUControl;
            model_advance(mem_ready);
            @(posedge clk); #1;
            cyc++;
        end
        if (!m_done) begin
            n_fail++;
            $display("FAIL instr_timeout: op=%b still running after %0d cycles, required completion", i_op, cyc);
        end
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [2:0] alu3;
        logic [1:0] imm;
        int         ret;
    } vec_t;

    vec_t        tbl[13];
    int          cyc;
    logic [15:0] rw_m, mw_m, pw_m, il_m;
    logic [2:0]  alu3;
    logic [1:0]  imm0;
    bit          immc;
    logic [31:0] tbl_ret;
    logic [6:0]  rop;
    logic [6:0]  ops[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00, 1};
        tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01, 1};
        tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1};
        tbl[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00, 1};
        tbl[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00, 1};
        tbl[5]  = '{7'b0110011, 3'b110, 1'b1, 1'b0, 4, 3'b011, 2'b00, 1};
        tbl[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1};
        tbl[7]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1};
        tbl[8]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1};
        tbl[9]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1};
        tbl[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10, 1};
        tbl[11] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00, 0};
        tbl[12] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00, 0};
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};

        // Reset held with mem_ready high: enables stay low, state is FETCH.
        model_reset();
        rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0000011;
        #12;
        check("reset IRWrite", IRWrite, 1'b0);
        check("reset PCWrite", PCWrite, 1'b0);
        check("reset retired", retired, 32'd0);
        check("reset ALUSrcB(fetch)", ALUSrcB, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tbl_ret = 32'd0;
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, P_FETCH, 0, 0,
                      cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
            tbl_ret = tbl_ret + 32'(tbl[i].ret);
            check($sformatf("tbl[%0d] latency", i), cyc, tbl[i].lat);
            check($sformatf("tbl[%0d] ImmSrc", i), {imm0, immc}, {tbl[i].imm, 1'b1});
            check($sformatf("tbl[%0d] retired", i), retired, tbl_ret);
            if (tbl[i].lat > 2) check($sformatf("tbl[%0d] ALUControl cyc3", i), alu3, tbl[i].alu3);
        end

        // lw: RegWrite only in cycle 5
        run_instr(7'b0000011, 3'b010, 0, 0, P_FETCH, 0, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("lw RegWrite cycles", rw_m, 16'h0010);
        check("lw latency", cyc, 5);
        // lw with 2 fetch stalls then 1 read stall
        run_instr(7'b0000011, 3'b010, 0, 0, P_FETCH, 2, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("lw fetch-stall latency", cyc, 7);
        run_instr(7'b0000011, 3'b010, 0, 0, P_LDRD, 1, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("lw read-stall latency", cyc, 6);
        check("lw read-stall RegWrite", rw_m, 16'h0020);
        // sw with 3 stall cycles in the write
        run_instr(7'b0100011, 3'b010, 0, 0, P_STWR, 3, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("sw MemWrite cycles", mw_m, 16'h0078);
        check("sw RegWrite never", rw_m, 16'h0000);
        check("sw latency", cyc, 7);
        // beq taken / not taken
        run_instr(7'b1100011, 3'b000, 0, 1, P_FETCH, 0, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("beq z=1 PCWrite cycles", pw_m, 16'h0005);
        check("beq z=1 ImmSrc", {imm0, immc}, {2'b10, 1'b1});
        run_instr(7'b1100011, 3'b000, 0, 0, P_FETCH, 0, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("beq z=0 PCWrite cycles", pw_m, 16'h0001);
        check("beq z=0 ImmSrc", {imm0, immc}, {2'b10, 1'b1});
        // illegal opcode
        tbl_ret = m_ret;
        run_instr(7'b1111111, 3'b000, 0, 0, P_FETCH, 0, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("illegal pulse", il_m, 16'h0002);
        check("illegal writes", {rw_m, mw_m, pw_m}, {16'h0000, 16'h0000, 16'h0001});
        check("illegal retired unchanged", retired, tbl_ret);

        // Counter wrap: deposit all-ones while idle in FETCH
        dut.r_retired = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        run_instr(7'b0010011, 3'b000, 0, 0, P_FETCH, 0, 0, cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        check("retired wrap", retired, 32'd0);

        // Asynchronous reset while waiting in MEMREAD
        op = 7'b0000011; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        check("in MEMREAD AdrSrc", AdrSrc, 1'b1);
        #1 rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check("async rst enables", {PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 5'b0);
        check("async rst state FETCH", {AdrSrc, ALUSrcB, ResultSrc}, {1'b0, 2'b10, 2'b10});
        check("async rst retired", retired, 32'd0);
        @(posedge clk); #1;
        check("held rst IRWrite", IRWrite, 1'b0);
        rst_n = 1'b1;
        model_reset();

        // Randomized run against the model
        for (int n = 0; n < 200; n++) begin
            rop = ($urandom_range(0, 5) == 5) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            run_instr(rop, 3'($urandom), 1'($urandom), 1'b0, P_FETCH, 0, 1,
                      cyc, rw_m, mw_m, pw_m, il_m, alu3, imm0, immc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
